// File: rtl/door_game_pkg.sv
// door_game_pkg: shared state encoding, door index width and LFSR constants for the door game.
package door_game_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, REVEAL, WIN, LOSE} game_state_t;
  localparam int DOOR_IDX_W = $clog2(4);
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
endpackage

// File: rtl/door_lfsr.sv
// door_lfsr: free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), exposes its low bits as a door pick.
module door_lfsr
  import door_game_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  output logic [DOOR_IDX_W-1:0] pick
);
  logic [7:0] q;
  always_ff @(posedge clk)
    q <= reset ? LFSR_SEED : {q[6:0], ^(q & LFSR_TAPS)};
  assign pick = q[DOOR_IDX_W-1:0];
endmodule

// File: rtl/door_game_controller.sv
// door_game_controller: frame-synchronous 4-door game FSM with shadowed display outputs; PRIZE_DEBUG_EN adds prize_dbg.
module door_game_controller
  import door_game_pkg::*;
#(
  parameter int NUM_DOORS     = 4,
  parameter int MAX_LIVES     = 3,
  parameter int REVEAL_FRAMES = 30,
  parameter int END_FRAMES    = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_select,
  output logic [NUM_DOORS-1:0]  door_open,
  output logic [DOOR_IDX_W-1:0] cursor,
  output logic [1:0]            lives,
  output logic                  state_win,
  output logic                  state_lose
`ifdef PRIZE_DEBUG_EN
  ,
  output logic [DOOR_IDX_W-1:0] prize_dbg
`endif
);
  localparam int CNT_W = $clog2((REVEAL_FRAMES > END_FRAMES ? REVEAL_FRAMES : END_FRAMES) + 1);
  localparam logic [CNT_W-1:0] END_CNT = CNT_W'(END_FRAMES);
  localparam logic [CNT_W-1:0] REV_LAST = CNT_W'(REVEAL_FRAMES - 1);
  localparam logic [DOOR_IDX_W-1:0] LAST_DOOR = DOOR_IDX_W'(NUM_DOORS - 1);
  game_state_t           state;
  logic [DOOR_IDX_W-1:0] cur, prize, pick;
  logic [NUM_DOORS-1:0]  mask;
  logic [1:0]            lv;
  logic [CNT_W-1:0]      cnt;
  door_lfsr u_lfsr (.clk(clk), .reset(reset), .pick(pick));
`ifdef PRIZE_DEBUG_EN
  assign prize_dbg = prize;
`endif
  // Internal state reacts to buttons immediately; the outputs only sample it on frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      mask       <= '0;
      lv         <= 2'(MAX_LIVES);
      prize      <= '0;
      cnt        <= '0;
      door_open  <= '0;
      cursor     <= '0;
      lives      <= 2'(MAX_LIVES);
      state_win  <= 1'b0;
      state_lose <= 1'b0;
    end else begin
      if (frame_start && cnt < END_CNT) cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (btn_select) begin
          state <= SELECT;
          mask  <= '0;
          lv    <= 2'(MAX_LIVES);
          cur   <= '0;
          prize <= pick;
        end
        SELECT: if (btn_select) begin
          if (!mask[cur]) begin
            mask[cur] <= 1'b1;
            cnt       <= '0;
            state     <= REVEAL;
          end
        end else if (btn_left && !btn_right) cur <= cur == '0 ? LAST_DOOR : cur - 1'b1;
        else if (btn_right && !btn_left) cur <= cur == LAST_DOOR ? '0 : cur + 1'b1;
        REVEAL: if (frame_start && cnt == REV_LAST) begin
          cnt <= '0;
          if (cur == prize) state <= WIN;
          else begin
            lv    <= lv - 1'b1;
            state <= lv == 2'd1 ? LOSE : SELECT;
          end
        end
        WIN, LOSE: if (btn_select && cnt == END_CNT) begin
          state <= IDLE;
          mask  <= '0;
        end
        default: state <= IDLE;
      endcase
      if (frame_start) begin
        door_open  <= mask;
        cursor     <= cur;
        lives      <= lv;
        state_win  <= state == WIN;
        state_lose <= state == LOSE;
      end
    end
  end
endmodule
